// File: rtl/ts_packet_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ts_packet_scheduler_pkg
//   Shared definitions for the TS packet scheduler: transport-stream packet
//   constants, the scheduler state encoding and a small wrap-around helper
//   used by the round-robin logic.
// ---------------------------------------------------------------------------
package ts_packet_scheduler_pkg;

   localparam int         TS_PKT_LEN   = 188;
   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PASS = 1'b1
   } sched_state_t;

   // Next channel index after v, wrapping at n.
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/ts_packet_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: returns the first asserted request at
//   or after ptr, scanning upward with wrap-around.
// Ports
//   req  in  NUM_CH  request vector
//   ptr  in  IDX_W   scan start index (highest priority this cycle)
//   gnt  out NUM_CH  one-hot grant, 0 when no request
//   idx  out IDX_W   index of the granted request (0 when none)
//   any  out 1       at least one request present
// ---------------------------------------------------------------------------
module rr_pick
   import ts_packet_scheduler_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt,
   output logic [IDX_W-1:0]  idx,
   output logic              any
);

   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = int'(ptr);
      for (int k = 0; k < NUM_CH; k++) begin
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
         j = wrap_inc(j, NUM_CH);
      end
   end

endmodule

// File: rtl/ts_packet_scheduler.sv
// ---------------------------------------------------------------------------
// ts_packet_scheduler
//   Packet-granular round-robin scheduler sharing one TS output path among
//   NUM_CH sync-recovered streams. A channel is granted for a whole packet;
//   arbitration happens only at packet starts. Inputs cannot stall, so any
//   packet start that is not granted is dropped and counted per channel.
// Ports
//   clk        in   1             clock, all logic on posedge
//   rst        in   1             synchronous active-low reset
//   ch_byte    in   NUM_CH*8      per-channel byte, ch i at [8*i+7:8*i]
//   ch_sop     in   NUM_CH        per-channel start-of-packet pulse
//   ch_en      in   NUM_CH        channel enable mask (used at grant time)
//   clr_cnt    in   1             synchronous clear of all drop counters
//   out_byte   out  8             forwarded byte
//   out_valid  out  1             out_byte valid
//   out_sop    out  1             first byte of a forwarded packet
//   out_abort  out  1             pulse: current packet truncated
//   out_ch     out  clog2(NUM_CH) channel of the forwarded packet
//   grant      out  NUM_CH        one-hot granted channel, 0 when idle
//   drop_cnt   out  NUM_CH*CNT_W  saturating dropped-SOP count per channel
// ---------------------------------------------------------------------------
module ts_packet_scheduler
   import ts_packet_scheduler_pkg::*;
#(
   parameter int         NUM_CH    = 4,
   parameter int         PKT_LEN   = TS_PKT_LEN,
   parameter logic [7:0] SYNC_BYTE = TS_SYNC_BYTE,
   parameter int         CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH*8-1:0]       ch_byte,
   input  logic [NUM_CH-1:0]         ch_sop,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic                      clr_cnt,
   output logic [7:0]                out_byte,
   output logic                      out_valid,
   output logic                      out_sop,
   output logic                      out_abort,
   output logic [$clog2(NUM_CH)-1:0] out_ch,
   output logic [NUM_CH-1:0]         grant,
   output logic [NUM_CH*CNT_W-1:0]   drop_cnt
);

   localparam int         IDX_W    = $clog2(NUM_CH);
   localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

   sched_state_t      state, state_nxt;
   logic [IDX_W-1:0]  sel, sel_nxt;
   logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [7:0]        byte_cnt, byte_cnt_nxt;

   logic [NUM_CH-1:0] cand;
   logic [NUM_CH-1:0] pick_gnt;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic [NUM_CH-1:0] sel_oh;
   logic [NUM_CH-1:0] drop_inc;

   logic [7:0]        byte_p0;
   logic              vld_p0;
   logic              sop_p0;
   logic              abort_p0;
   logic [IDX_W-1:0]  ch_p0;
   logic [NUM_CH-1:0] grant_p0;

   logic [CNT_W-1:0]  cnt_q [NUM_CH];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A channel may start a packet only on a real sync byte while enabled.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cand[i] = ch_sop[i] & ch_en[i] & (ch_byte[8*i +: 8] == SYNC_BYTE);
      end
   end

   assign sel_oh = NUM_CH'(1) << sel;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_rr_pick (
      .req (cand),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // ---- stage p0: arbitration / next-state and output selection ----
   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      rr_ptr_nxt   = rr_ptr;
      byte_cnt_nxt = byte_cnt;
      byte_p0      = out_byte;
      vld_p0       = 1'b0;
      sop_p0       = 1'b0;
      abort_p0     = 1'b0;
      ch_p0        = out_ch;
      grant_p0     = '0;
      drop_inc     = '0;
      unique case (state)
         S_IDLE: begin
            drop_inc = cand & ~pick_gnt;
            if (pick_any) begin
               state_nxt    = S_PASS;
               sel_nxt      = pick_idx;
               byte_cnt_nxt = 8'd1;
               byte_p0      = ch_byte[8*int'(pick_idx) +: 8];
               vld_p0       = 1'b1;
               sop_p0       = 1'b1;
               ch_p0        = pick_idx;
               grant_p0     = pick_gnt;
            end
         end
         S_PASS: begin
            // Other channels cannot be serviced mid-packet: their SOPs are lost.
            drop_inc = cand & ~sel_oh;
            if (ch_sop[sel]) begin
               // The granted stream restarted early: truncate and re-arbitrate.
               drop_inc[sel] = 1'b1;
               abort_p0      = 1'b1;
               state_nxt     = S_IDLE;
               rr_ptr_nxt    = IDX_W'(wrap_inc(int'(sel), NUM_CH));
               byte_cnt_nxt  = '0;
            end else begin
               byte_p0      = ch_byte[8*int'(sel) +: 8];
               vld_p0       = 1'b1;
               grant_p0     = sel_oh;
               byte_cnt_nxt = byte_cnt + 8'd1;
               if (byte_cnt == LAST_IDX) begin
                  state_nxt    = S_IDLE;
                  rr_ptr_nxt   = IDX_W'(wrap_inc(int'(sel), NUM_CH));
                  byte_cnt_nxt = '0;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- stage p1: state and output registers ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         sel       <= '0;
         rr_ptr    <= '0;
         byte_cnt  <= '0;
         out_byte  <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_abort <= 1'b0;
         out_ch    <= '0;
         grant     <= '0;
      end else begin
         state     <= state_nxt;
         sel       <= sel_nxt;
         rr_ptr    <= rr_ptr_nxt;
         byte_cnt  <= byte_cnt_nxt;
         out_byte  <= byte_p0;
         out_valid <= vld_p0;
         out_sop   <= sop_p0;
         out_abort <= abort_p0;
         out_ch    <= ch_p0;
         grant     <= grant_p0;
      end
   end

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst || clr_cnt) begin
            cnt_q[i] <= '0;
         end else if (drop_inc[i]) begin
            cnt_q[i] <= sat_inc(cnt_q[i]);
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign drop_cnt[CNT_W*g +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_ts_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ts_packet_scheduler
//   Self-checking bench: a packet-level reference model tracks what the
//   scheduler must emit each cycle and a compare process checks the DUT on
//   every falling edge. Directed scenarios pin the model with literal values;
//   a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ts_packet_scheduler;

   localparam int N  = 4;
   localparam int L  = 188;
   localparam int CW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N*8-1:0]  ch_byte = '0;
   logic [N-1:0]    ch_sop = '0;
   logic [N-1:0]    ch_en = '1;
   logic            clr_cnt = 1'b0;
   logic [7:0]      out_byte;
   logic            out_valid;
   logic            out_sop;
   logic            out_abort;
   logic [1:0]      out_ch;
   logic [N-1:0]    grant;
   logic [N*CW-1:0] drop_cnt;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   ts_packet_scheduler #(
      .NUM_CH    (N),
      .PKT_LEN   (L),
      .SYNC_BYTE (8'h47),
      .CNT_W     (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_byte   (ch_byte),
      .ch_sop    (ch_sop),
      .ch_en     (ch_en),
      .clr_cnt   (clr_cnt),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_sop   (out_sop),
      .out_abort (out_abort),
      .out_ch    (out_ch),
      .grant     (grant),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit         m_busy;
   int         m_sel, m_cnt, m_ptr;
   int         m_drop [N];
   logic [7:0] e_byte;
   logic       e_valid, e_sop, e_abort;
   logic [1:0] e_ch;
   logic [N-1:0] e_grant;

   always @(posedge clk) begin : model
      bit is_cand [N];
      bit inc [N];
      int win;
      if (!rst) begin
         m_busy = 0; m_sel = 0; m_cnt = 0; m_ptr = 0;
         for (int i = 0; i < N; i++) m_drop[i] = 0;
         e_byte = '0; e_valid = 0; e_sop = 0; e_abort = 0; e_ch = '0; e_grant = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            is_cand[i] = ch_sop[i] && ch_en[i] && (ch_byte[8*i +: 8] == 8'h47);
            inc[i] = 0;
         end
         e_valid = 0; e_sop = 0; e_abort = 0; e_grant = '0;
         if (!m_busy) begin
            win = -1;
            for (int k = 0; k < N; k++)
               if (win < 0 && is_cand[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            for (int i = 0; i < N; i++) if (is_cand[i] && i != win) inc[i] = 1;
            if (win >= 0) begin
               m_busy = 1; m_sel = win; m_cnt = 1;
               e_byte = ch_byte[8*win +: 8]; e_valid = 1; e_sop = 1;
               e_ch = 2'(win); e_grant = N'(1 << win);
            end
         end else begin
            for (int i = 0; i < N; i++) if (is_cand[i] && i != m_sel) inc[i] = 1;
            if (ch_sop[m_sel]) begin
               inc[m_sel] = 1; e_abort = 1; m_busy = 0; m_ptr = (m_sel + 1) % N;
            end else begin
               e_byte = ch_byte[8*m_sel +: 8]; e_valid = 1; e_grant = N'(1 << m_sel);
               m_cnt++;
               if (m_cnt == L) begin m_busy = 0; m_ptr = (m_sel + 1) % N; end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (clr_cnt) m_drop[i] = 0;
            else if (inc[i] && m_drop[i] < (1 << CW) - 1) m_drop[i]++;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ctrl", {out_valid, out_sop, out_abort, grant}, {e_valid, e_sop, e_abort, e_grant});
         if (e_valid) chk("out_ch", out_ch, e_ch);
         chk("out_byte", out_byte, e_byte);
         for (int i = 0; i < N; i++) chk("drop_cnt", drop_cnt[CW*i +: CW], 64'(m_drop[i]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      ch_sop  = '0;
      ch_byte = $urandom;
   endtask

   function automatic logic [CW-1:0] dc(input int i);
      return drop_cnt[CW*i +: CW];
   endfunction

   task automatic do_reset();
      quiet();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic run_packet(input int ch, output int nv, output int ns);
      quiet();
      ch_byte[8*ch +: 8] = 8'h47;
      ch_sop[ch] = 1'b1;
      step();
      nv = int'(out_valid);
      ns = int'(out_sop);
      for (int b = 1; b < L; b++) begin
         quiet();
         ch_byte[8*ch +: 8] = 8'(b);
         step();
         nv += int'(out_valid);
         ns += int'(out_sop);
      end
   endtask

   task automatic body(input int ch, input int nbytes);
      for (int b = 0; b < nbytes; b++) begin
         quiet();
         ch_byte[8*ch +: 8] = 8'(b + 1);
         step();
      end
   endtask

   initial begin
      int nv, ns, nv2, ns2;
      quiet();
      ch_en = 4'hF;
      rst = 1'b0;
      step();
      step();
      chk_en = 1'b1;
      chk("reset_valid", out_valid, 0);
      chk("reset_grant", grant, 0);
      chk("reset_drop", drop_cnt, 0);
      rst = 1'b1;
      step();

      // 1: single ch0 packet
      run_packet(0, nv, ns);
      chk("t1_valid_count", nv, 188);
      chk("t1_sop_count", ns, 1);
      chk("t1_last_byte", out_byte, 8'hBB);
      quiet();
      step();
      chk("t1_idle_valid", out_valid, 0);
      chk("t1_idle_grant", grant, 0);
      chk("t1_hold_byte", out_byte, 8'hBB);

      // 2: all four SOPs together, twice
      do_reset();
      quiet();
      ch_byte = {4{8'h47}};
      ch_sop = 4'hF;
      step();
      chk("t2_first_ch", out_ch, 0);
      chk("t2_first_grant", grant, 4'b0001);
      chk("t2_drops", {dc(3), dc(2), dc(1), dc(0)}, {8'd1, 8'd1, 8'd1, 8'd0});
      body(0, L - 1);
      quiet();
      ch_byte = {4{8'h47}};
      ch_sop = 4'hF;
      step();
      chk("t2_second_ch", out_ch, 1);
      chk("t2_drops2", {dc(3), dc(2), dc(1), dc(0)}, {8'd2, 8'd2, 8'd1, 8'd1});
      body(1, L - 1);

      // 3: back-to-back ch2 packets
      run_packet(2, nv, ns);
      run_packet(2, nv2, ns2);
      chk("t3_contig_valid", nv + nv2, 376);
      chk("t3_sops", ns + ns2, 2);
      chk("t3_drops", {dc(3), dc(2), dc(1), dc(0)}, {8'd2, 8'd2, 8'd1, 8'd1});
      quiet();
      step();

      // 4: early SOP on granted ch1 at byte 100
      quiet();
      ch_byte[15:8] = 8'h47;
      ch_sop[1] = 1'b1;
      step();
      chk("t4_grant_ch", out_ch, 1);
      body(1, 99);
      quiet();
      ch_byte[15:8] = 8'h47;
      ch_sop[1] = 1'b1;
      step();
      chk("t4_abort", {out_abort, out_valid, grant}, {1'b1, 1'b0, 4'b0000});
      chk("t4_drop1", dc(1), 2);
      quiet();
      step();
      chk("t4_after", {out_abort, out_valid}, 2'b00);

      // 5: only ch1 enabled
      ch_en = 4'b0010;
      for (int p = 0; p < 3; p++) begin
         quiet();
         ch_byte = {4{8'h47}};
         ch_sop = 4'hF;
         step();
         chk("t5_ch", {out_sop, out_ch}, {1'b1, 2'd1});
         body(1, L - 1);
      end
      chk("t5_drops", {dc(3), dc(2), dc(1), dc(0)}, {8'd2, 8'd2, 8'd2, 8'd1});
      quiet();
      ch_byte[15:8] = 8'h12;
      ch_sop[1] = 1'b1;
      step();
      chk("t5_bad_sync", out_valid, 0);
      quiet();
      step();

      // 6: saturation and clear priority
      ch_en = 4'b1000;
      for (int c = 0; c < 600; c++) begin
         quiet();
         ch_byte[31:24] = 8'h47;
         ch_sop[3] = 1'b1;
         step();
      end
      chk("t6_saturated", dc(3), 8'hFF);
      clr_cnt = 1'b1;
      step();
      step();
      chk("t6_clear", drop_cnt, 0);
      clr_cnt = 1'b0;
      for (int c = 0; c < 200; c++) begin
         quiet();
         step();
      end

      // 7: reset in the middle of a packet
      ch_en = 4'hF;
      quiet();
      ch_byte[7:0] = 8'h47;
      ch_byte[15:8] = 8'h47;
      ch_sop = 4'b0011;
      step();
      chk("t7_grant0", out_ch, 0);
      chk("t7_drop1", dc(1), 1);
      body(0, 49);
      quiet();
      rst = 1'b0;
      step();
      chk("t7_reset_out", {out_valid, out_sop, grant, out_byte}, 0);
      chk("t7_reset_cnt", drop_cnt, 0);
      rst = 1'b1;
      quiet();
      step();
      quiet();
      ch_byte[23:16] = 8'h47;
      ch_sop[2] = 1'b1;
      step();
      chk("t7_new_sop", {out_sop, out_ch, grant}, {1'b1, 2'd2, 4'b0100});
      body(2, L - 1);

      // randomized traffic against the model
      do_reset();
      ch_en = 4'hF;
      for (int c = 0; c < 20000; c++) begin
         rst = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
         clr_cnt = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 199) == 0) ch_en = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            ch_sop[i] = ($urandom_range(0, 119) == 0);
            ch_byte[8*i +: 8] = (ch_sop[i] && $urandom_range(0, 9) != 0) ? 8'h47 : 8'($urandom);
         end
         step();
      end
      rst = 1'b1;
      clr_cnt = 1'b0;
      quiet();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
